// File: rtl/tpu_result_drain.sv
// Purpose: buffers result-SRAM rows in a small FIFO and serialises each row into OUT_WIDTH-bit stream beats.
// Latency: a row written at edge N presents beat 0 right after edge N; one beat per cycle while out_ready is high.
// Backpressure: out_ready=0 freezes the current beat; rows arriving while the FIFO is full are dropped and overflow sticks.
//
// Ports:
//   clk, srst                          clock, asynchronous active-high reset
//   sram_write_enable/waddr/wdata      row write port from tpu_top (lane k at bits [k*OUTPUT_DATA_WIDTH +: OUTPUT_DATA_WIDTH])
//   tpu_done                           end-of-job pulse; turned into drain_done once all accepted rows have left
//   out_valid/ready/data/addr/beat/last  beat stream toward host/DMA
//   fifo_level                         rows held, including the one streaming
//   overflow                           sticky row-drop flag
//   drain_done                         single-cycle completion pulse
module tpu_result_drain #(
  parameter int ARRAY_SIZE        = 32,
  parameter int OUTPUT_DATA_WIDTH = 32,
  parameter int ADDR_WIDTH        = 6,
  parameter int OUT_WIDTH         = 64,
  parameter int FIFO_DEPTH        = 4,
  localparam int ROW_W  = ARRAY_SIZE * OUTPUT_DATA_WIDTH,
  localparam int BEATS  = ROW_W / OUT_WIDTH,
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1,
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1,
  localparam int LVL_W  = PTR_W + 1
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic                  sram_write_enable,
  input  logic [ADDR_WIDTH-1:0] sram_waddr,
  input  logic [ROW_W-1:0]      sram_wdata,
  input  logic                  tpu_done,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [BEAT_W-1:0]     out_beat,
  output logic                  out_last,
  output logic [LVL_W-1:0]      fifo_level,
  output logic                  overflow,
  output logic                  drain_done
);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [ROW_W-1:0]      data;
  } row_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_DONE
  } state_t;

  row_t             mem [FIFO_DEPTH];
  row_t             head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] level_q;
  logic [LVL_W-1:0] level_d;
  logic [BEAT_W-1:0] beat_q;
  state_t           state_q;
  state_t           state_d;
  logic             done_pending_q;
  logic             done_pending_d;
  logic             overflow_q;

  logic full;
  logic last_beat;
  logic hs;
  logic pop;
  logic push;
  logic drop;
  logic empty_after;
  logic pend_any;

  assign full      = (level_q == LVL_W'(FIFO_DEPTH));
  assign last_beat = (beat_q == BEAT_W'(BEATS - 1));
  assign hs        = (state_q == S_STREAM) && out_ready;
  assign pop       = hs && last_beat;
  // A full FIFO still takes a row when the head leaves on the same edge:
  // the freed slot is exactly the one wr_ptr points at.
  assign push      = sram_write_enable && (!full || pop);
  assign drop      = sram_write_enable && full && !pop;
  assign level_d   = level_q + LVL_W'(push) - LVL_W'(pop);
  assign empty_after = (level_d == '0);
  // tpu_done is folded in directly so completion is judged on this edge,
  // with a same-edge push already counted in level_d.
  assign pend_any  = done_pending_q || tpu_done;

  always_comb begin
    state_d        = state_q;
    done_pending_d = pend_any;
    case (state_q)
      S_IDLE: begin
        if (!empty_after)  state_d = S_STREAM;
        else if (pend_any) state_d = S_DONE;
      end
      S_STREAM: begin
        if (pop && empty_after) state_d = pend_any ? S_DONE : S_IDLE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (state_d == S_DONE) done_pending_d = 1'b0;
  end

  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      state_q        <= S_IDLE;
      done_pending_q <= 1'b0;
      overflow_q     <= 1'b0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      level_q        <= '0;
      beat_q         <= '0;
    end else begin
      state_q        <= state_d;
      done_pending_q <= done_pending_d;
      level_q        <= level_d;
      if (drop) overflow_q <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (pop)     beat_q <= '0;
      else if (hs) beat_q <= beat_q + 1'b1;
    end
  end

  // Row storage carries no reset; stale contents are never visible because
  // the payload outputs are gated by out_valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{addr: sram_waddr, data: sram_wdata};
  end

  assign head       = mem[rd_ptr];
  assign out_valid  = (state_q == S_STREAM);
  assign out_data   = out_valid ? head.data[beat_q * OUT_WIDTH +: OUT_WIDTH] : '0;
  assign out_addr   = out_valid ? head.addr : '0;
  assign out_beat   = beat_q;
  assign out_last   = out_valid && last_beat;
  assign fifo_level = level_q;
  assign overflow   = overflow_q;
  assign drain_done = (state_q == S_DONE);

endmodule

// File: tb/tb_tpu_result_drain.sv
// Purpose: directed bench for tpu_result_drain with a queue-based reference model.
// Latency: model predicts outputs for every cycle; literal expectations pin key beats and timings.
// Backpressure: out_ready patterns (always, 1-in-3, held low) exercise stalls and row drops.
module tb_tpu_result_drain;
  localparam int AW    = 6;
  localparam int ROW_W = 32 * 32;
  localparam int BEATS = 16;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            srst;
  logic            we;
  logic [AW-1:0]   waddr;
  logic [ROW_W-1:0] wdata;
  logic            tpu_done;
  logic            out_valid;
  logic            out_ready;
  logic [63:0]     out_data;
  logic [AW-1:0]   out_addr;
  logic [3:0]      out_beat;
  logic            out_last;
  logic [2:0]      fifo_level;
  logic            overflow;
  logic            drain_done;

  always #5 clk = ~clk;

  tpu_result_drain dut (
    .clk(clk), .srst(srst),
    .sram_write_enable(we), .sram_waddr(waddr), .sram_wdata(wdata),
    .tpu_done(tpu_done),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_addr(out_addr), .out_beat(out_beat), .out_last(out_last),
    .fifo_level(fifo_level), .overflow(overflow), .drain_done(drain_done)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [ROW_W-1:0] mk_row(input int seed);
    logic [ROW_W-1:0] r;
    for (int k = 0; k < 32; k++) r[k*32 +: 32] = (32'(seed) << 16) | 32'(k);
    return r;
  endfunction

  // ---------------- reference model ----------------
  // Rows waiting to be streamed, the beat index into the head row, and the
  // completion bookkeeping: a pending job end fires once the queue is empty;
  // the cycle after the pulse is an idle cycle before streaming resumes.
  typedef struct {
    logic [AW-1:0]    addr;
    logic [ROW_W-1:0] data;
  } mrow_t;

  mrow_t mq[$];
  int    mb = 0;
  bit    m_ovf = 0, m_pend = 0, m_done = 0, m_after_done = 0;

  function automatic bit m_valid();
    return (mq.size() > 0) && !m_done && !m_after_done;
  endfunction

  always @(posedge clk or posedge srst) begin
    if (srst) begin
      mq.delete();
      mb = 0; m_ovf = 0; m_pend = 0; m_done = 0; m_after_done = 0;
    end else begin
      bit    hs, pop, was_done;
      mrow_t r;
      hs  = m_valid() && out_ready;
      pop = hs && (mb == BEATS - 1);
      if (hs) mb = pop ? 0 : mb + 1;
      if (pop) void'(mq.pop_front());
      if (we) begin
        if (mq.size() < DEPTH) begin
          r.addr = waddr; r.data = wdata;
          mq.push_back(r);
        end else begin
          m_ovf = 1;
        end
      end
      if (tpu_done) m_pend = 1;
      was_done     = m_done;
      m_done       = m_pend && (mq.size() == 0) && !was_done;
      if (m_done) m_pend = 0;
      m_after_done = was_done;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (srst) begin
      check("rst_valid", out_valid, 0);
      check("rst_data", out_data, 0);
      check("rst_addr", out_addr, 0);
      check("rst_beat", out_beat, 0);
      check("rst_last", out_last, 0);
      check("rst_level", fifo_level, 0);
      check("rst_ovf", overflow, 0);
      check("rst_done", drain_done, 0);
    end else begin
      check("out_valid", out_valid, m_valid());
      check("fifo_level", fifo_level, mq.size());
      check("overflow", overflow, m_ovf);
      check("drain_done", drain_done, m_done);
      if (m_valid()) begin
        check("out_data", out_data, mq[0].data[mb*64 +: 64]);
        check("out_addr", out_addr, mq[0].addr);
        check("out_beat", out_beat, mb);
        check("out_last", out_last, mb == BEATS - 1);
      end
    end
  end

  // ---------------- event monitor ----------------
  logic        mon_clr = 1'b0;
  int          cyc_n = 0, hs_cnt = 0, done_cnt = 0, max_level = 0;
  int          last_hs_at = 0, first_hs_at = 0, done_at = 0, tdone_at = 0;
  logic [63:0] first_data = '0, last_data = '0;
  logic [AW-1:0] first_addr = '0, last_addr = '0;
  logic [3:0]  first_beat_idx = '0;

  always @(negedge clk) begin
    if (mon_clr) begin
      hs_cnt = 0; done_cnt = 0; max_level = 0;
    end
    if (!srst) begin
      cyc_n++;
      if (tpu_done) tdone_at = cyc_n;
      if (drain_done) begin done_cnt++; done_at = cyc_n; end
      if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
      if (out_valid && out_ready) begin
        hs_cnt++;
        if (hs_cnt == 1) begin
          first_data = out_data; first_addr = out_addr;
          first_beat_idx = out_beat; first_hs_at = cyc_n;
        end
        last_data = out_data; last_addr = out_addr; last_hs_at = cyc_n;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    mon_clr = 1'b1;
    tick();
    mon_clr = 1'b0;
  endtask

  task automatic write_row(input logic [AW-1:0] a, input logic [ROW_W-1:0] d);
    we = 1'b1; waddr = a; wdata = d;
    tick();
    we = 1'b0;
  endtask

  task automatic drain(input string nm, input int lim);
    bit ok;
    ok = 0;
    for (int i = 0; i < lim; i++) begin
      if (!out_valid && fifo_level == 0) begin ok = 1; break; end
      tick();
    end
    check(nm, ok, 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    srst = 1'b1; we = 1'b0; waddr = '0; wdata = '0; tpu_done = 1'b0; out_ready = 1'b0;
    repeat (3) tick();
    check("reset_valid", out_valid, 0);
    check("reset_level", fifo_level, 0);
    srst = 1'b0;
    tick();

    // 1: single row, lane k = k
    out_ready = 1'b1;
    clear_mon();
    write_row(6'd5, mk_row(0));
    check("s1_valid_rise", out_valid, 1);
    drain("s1_drain", 100);
    tick();
    check("s1_hs", hs_cnt, 16);
    check("s1_beat0", first_data, 64'h00000001_00000000);
    check("s1_beat15", last_data, 64'h0000001F_0000001E);
    check("s1_addr", first_addr, 5);
    check("s1_level", fifo_level, 0);

    // 2: backpressure, ready one cycle in three
    out_ready = 1'b0;
    clear_mon();
    write_row(6'd5, mk_row(0));
    for (int i = 0; i < 48; i++) begin
      out_ready = (i % 3 == 2);
      tick();
    end
    out_ready = 1'b0;
    check("s2_hs", hs_cnt, 16);
    check("s2_beat0", first_data, 64'h00000001_00000000);
    check("s2_beat15", last_data, 64'h0000001F_0000001E);
    check("s2_level", fifo_level, 0);
    tick();

    // 3: back-to-back rows 0..3
    out_ready = 1'b1;
    clear_mon();
    for (int a = 0; a < 4; a++) write_row(6'(a), mk_row(a + 1));
    drain("s3_drain", 200);
    tick();
    check("s3_hs", hs_cnt, 64);
    check("s3_no_gap", last_hs_at - first_hs_at + 1, 64);
    check("s3_peak", max_level, 4);
    check("s3_first_addr", first_addr, 0);
    check("s3_last_addr", last_addr, 3);
    check("s3_ovf", overflow, 0);

    // 4: overflow with ready held low
    out_ready = 1'b0;
    clear_mon();
    for (int a = 1; a <= 5; a++) write_row(6'(a), mk_row(a + 10));
    check("s4_level", fifo_level, 4);
    check("s4_ovf", overflow, 1);
    out_ready = 1'b1;
    drain("s4_drain", 200);
    tick();
    check("s4_hs", hs_cnt, 64);
    check("s4_last_addr", last_addr, 4);
    check("s4_ovf_sticky", overflow, 1);

    // 5a: tpu_done mid-stream over two rows
    clear_mon();
    write_row(6'd10, mk_row(20));
    write_row(6'd11, mk_row(21));
    repeat (8) tick();
    tpu_done = 1'b1; tick(); tpu_done = 1'b0;
    drain("s5a_drain", 100);
    repeat (3) tick();
    check("s5a_hs", hs_cnt, 32);
    check("s5a_done_cnt", done_cnt, 1);
    check("s5a_done_time", done_at, last_hs_at + 1);

    // 5b: tpu_done with the FIFO already empty
    clear_mon();
    tpu_done = 1'b1; tick(); tpu_done = 1'b0;
    repeat (3) tick();
    check("s5b_done_cnt", done_cnt, 1);
    check("s5b_done_time", done_at, tdone_at + 1);

    // 5c: two tpu_done pulses while a row is streaming
    clear_mon();
    write_row(6'd20, mk_row(30));
    repeat (2) tick();
    tpu_done = 1'b1; tick(); tpu_done = 1'b0; tick();
    tpu_done = 1'b1; tick(); tpu_done = 1'b0;
    drain("s5c_drain", 100);
    repeat (3) tick();
    check("s5c_done_cnt", done_cnt, 1);

    // 6: asynchronous reset at beat 7
    clear_mon();
    write_row(6'd3, mk_row(40));
    begin
      bit found;
      found = 0;
      for (int i = 0; i < 40; i++) begin
        if (out_valid && out_beat == 4'd7) begin found = 1; break; end
        tick();
      end
      check("s6_reach_beat7", found, 1);
    end
    #2 srst = 1'b1;
    #1;
    check("s6_valid", out_valid, 0);
    check("s6_level", fifo_level, 0);
    check("s6_ovf", overflow, 0);
    check("s6_beat", out_beat, 0);
    check("s6_data", out_data, 0);
    repeat (2) tick();
    #3 srst = 1'b0;
    tick();
    clear_mon();
    write_row(6'd9, mk_row(50));
    drain("s6_drain", 100);
    tick();
    check("s6_hs", hs_cnt, 16);
    check("s6_first_addr", first_addr, 9);
    check("s6_first_beat", first_beat_idx, 0);
    check("s6_first_data", first_data, {32'h00320001, 32'h00320000});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
